// File: rtl/sm_pkg.sv
// Shared-memory subsystem types: address/length widths, the read command and the reader FSM encoding.
package sm_pkg;

   localparam int SM_ADDR_W = 10;
   localparam int SM_LEN_W  = 16;

   typedef struct packed {
      logic [SM_ADDR_W-1:0] addr;
      logic [SM_LEN_W-1:0]  len;
   } sm_cmd_t;

   typedef enum logic {
      RD_IDLE,
      RD_READ
   } sm_rd_state_t;

endpackage

// File: rtl/sm_rd_fifo.sv
// Show-ahead FIFO for the reader output path; the head entry is visible whenever valid_o is high.
module sm_rd_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   used_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   used_q;

   // Writer never overruns: the reader only issues reads it has space reserved for.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_en_i, rd_en_i})
            2'b10:   used_q <= used_q + (PTR_W+1)'(1);
            2'b01:   used_q <= used_q - (PTR_W+1)'(1);
            default: used_q <= used_q;
         endcase
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign valid_o   = (used_q != '0);
   assign used_o    = used_q;

endmodule

// File: rtl/sm_pkt_reader.sv
// Shared-memory packet reader: one command in, one Avalon-ST packet out.
// Optional SM_PKT_READER_STATS_EN adds saturating packet and zero-length-command counters.
//
//   state   | meaning
//   RD_IDLE | ready for a command; len==0 commands are consumed here
//   RD_READ | issuing word reads under FIFO credit; leaves on the last read
module sm_pkt_reader
   import sm_pkg::*;
#(
   parameter int AST_DATA_W  = 32,
   parameter int AST_EMPTY_W = (AST_DATA_W/8)-1,
   parameter int RD_LATENCY  = 2,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  sm_cmd_t                sm_cmd_data_i,
   input  logic                   sm_cmd_valid_i,
   output logic                   sm_cmd_ready_o,
   output logic                   mem_rd_en_o,
   output logic [SM_ADDR_W-1:0]   mem_rd_addr_o,
   input  logic [AST_DATA_W-1:0]  mem_rd_data_i,
   input  logic                   ast_src_ready_i,
   output logic                   ast_src_valid_o,
   output logic [AST_DATA_W-1:0]  ast_src_data_o,
   output logic                   ast_src_sop_o,
   output logic                   ast_src_eop_o,
   output logic [AST_EMPTY_W-1:0] ast_src_empty_o
`ifdef SM_PKT_READER_STATS_EN
   ,
   output logic [31:0]            stat_pkt_cnt_o,
   output logic [15:0]            stat_zero_len_o
`endif
);

   localparam int BYTES = AST_DATA_W/8;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TAG_W = 2 + AST_EMPTY_W;
   localparam logic [SM_LEN_W:0] BYTES_L = (SM_LEN_W+1)'(BYTES);

   sm_rd_state_t state_q, state_d;

   logic [SM_ADDR_W-1:0]   addr_q;
   logic [SM_LEN_W:0]      words_left_q;
   logic [AST_EMPTY_W-1:0] last_empty_q;
   logic                   first_q;
   logic [CNT_W-1:0]       inflight_q;
   logic [TAG_W-1:0]       pipe_q [RD_LATENCY];
   logic [RD_LATENCY-1:0]  pipe_v_q;

   logic                   cmd_fire;
   logic                   rd_issue;
   logic                   last_word;
   logic [SM_LEN_W:0]      len_ext;
   logic [SM_LEN_W:0]      words_full;
   logic [CNT_W-1:0]       fifo_used;
   logic                   fifo_valid;
   logic                   fifo_pop;
   logic [AST_DATA_W+TAG_W-1:0] fifo_head;

   assign cmd_fire   = sm_cmd_valid_i & sm_cmd_ready_o;
   assign rd_issue   = mem_rd_en_o;
   assign last_word  = (words_left_q == (SM_LEN_W+1)'(1));
   assign len_ext    = {1'b0, sm_cmd_data_i.len};
   assign words_full = (len_ext + BYTES_L - (SM_LEN_W+1)'(1)) / BYTES_L;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= RD_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: if (cmd_fire && sm_cmd_data_i.len != '0) state_d = RD_READ;
         RD_READ: if (rd_issue && last_word)               state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
   end

   // Credit: words already buffered plus reads still in the memory pipe must fit the FIFO.
   always_comb begin
      sm_cmd_ready_o = 1'b0;
      mem_rd_en_o    = 1'b0;
      case (state_q)
         RD_IDLE: sm_cmd_ready_o = ~rst_i;
         RD_READ: mem_rd_en_o = (words_left_q != '0) &&
                     (({1'b0, fifo_used} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH));
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q       <= '0;
         words_left_q <= '0;
         last_empty_q <= '0;
         first_q      <= 1'b0;
         inflight_q   <= '0;
         pipe_v_q     <= '0;
         for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
      end else begin
         if (cmd_fire) begin
            addr_q       <= sm_cmd_data_i.addr;
            words_left_q <= words_full;
            last_empty_q <= AST_EMPTY_W'((BYTES_L - (len_ext % BYTES_L)) % BYTES_L);
            first_q      <= 1'b1;
         end else if (rd_issue) begin
            addr_q       <= addr_q + SM_ADDR_W'(1);
            words_left_q <= words_left_q - (SM_LEN_W+1)'(1);
            first_q      <= 1'b0;
         end
         case ({rd_issue, pipe_v_q[RD_LATENCY-1]})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= inflight_q - CNT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
         pipe_v_q[0] <= rd_issue;
         pipe_q[0]   <= {first_q, last_word, last_word ? last_empty_q : AST_EMPTY_W'(0)};
         for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_v_q[k] <= pipe_v_q[k-1];
            pipe_q[k]   <= pipe_q[k-1];
         end
      end
   end

   assign fifo_pop = fifo_valid & ast_src_ready_i;

   sm_rd_fifo #(
      .WIDTH (AST_DATA_W + TAG_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (pipe_v_q[RD_LATENCY-1]),
      .wr_data_i ({mem_rd_data_i, pipe_q[RD_LATENCY-1]}),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_head),
      .valid_o   (fifo_valid),
      .used_o    (fifo_used)
   );

   assign mem_rd_addr_o   = addr_q;
   assign ast_src_valid_o = fifo_valid;
   assign ast_src_data_o  = fifo_valid ? fifo_head[TAG_W +: AST_DATA_W] : '0;
   assign ast_src_sop_o   = fifo_valid & fifo_head[TAG_W-1];
   assign ast_src_eop_o   = fifo_valid & fifo_head[TAG_W-2];
   assign ast_src_empty_o = fifo_valid ? fifo_head[AST_EMPTY_W-1:0] : '0;

`ifdef SM_PKT_READER_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_pkt_cnt_o  <= '0;
         stat_zero_len_o <= '0;
      end else begin
         if (fifo_pop && ast_src_eop_o && stat_pkt_cnt_o != '1)
            stat_pkt_cnt_o <= stat_pkt_cnt_o + 32'd1;
         if (cmd_fire && sm_cmd_data_i.len == '0 && stat_zero_len_o != '1)
            stat_zero_len_o <= stat_zero_len_o + 16'd1;
      end
   end
`endif

endmodule
